// File: rtl/agc_trace_capture.sv
// rtl/agc_trace_capture.sv - circular trace buffer with masked trigger, post-trigger count and cycle timeout
module agc_trace_capture #(
  parameter int WIDTH      = 16,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 64,
  parameter int POST       = 16,
  parameter int MAX_CYCLES = 500,
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW  = $clog2(DEPTH),
  localparam int CCW = $clog2(MAX_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] probe,
  input  logic                      probe_valid,
  input  logic                      arm,
  input  logic [CW-1:0]             trig_chan,
  input  logic [WIDTH-1:0]          trig_value,
  input  logic [WIDTH-1:0]          trig_mask,
  input  logic [AW-1:0]             rd_addr,
  input  logic [CW-1:0]             rd_chan,
  output logic [WIDTH-1:0]          rd_data,
  output logic [1:0]                state,
  output logic [AW:0]               sample_count,
  output logic [AW-1:0]             trig_index,
  output logic                      triggered,
  output logic                      timeout,
  output logic [CCW-1:0]            cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  POST_L  = AW'(POST);
  localparam logic [CCW-1:0] LIMIT_L = CCW'(MAX_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [AW-1:0]             r_wr_ptr;
  logic [AW-1:0]             r_trig_addr;
  logic [AW-1:0]             r_post_cnt;
  logic [AW:0]               r_sample_count;
  logic                      r_triggered;
  logic                      r_timeout;
  logic [CCW-1:0]            r_cycle_count;
  logic [WIDTH-1:0]          r_rd_data;
  logic [CHANNELS*WIDTH-1:0] r_mem [DEPTH];

  logic                      w_active;
  logic                      w_limit;
  logic                      w_hit;
  logic                      w_post_done;
  logic                      w_set_timeout;
  logic                      w_wr_en;
  logic [WIDTH-1:0]          w_trig_word;
  logic                      w_trig_ok;
  logic                      w_trig_match;
  logic [AW-1:0]             w_oldest;
  logic [AW-1:0]             w_rd_phys;
  logic [CHANNELS*WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0]          w_rd_sel;
  logic                      w_rd_chan_ok;
  logic                      w_rd_in_range;

  // Channel select by loop so an out-of-range trig_chan simply never matches.
  always_comb begin
    w_trig_word = '0;
    w_trig_ok   = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(trig_chan) == c) begin
        w_trig_word = probe[c*WIDTH +: WIDTH];
        w_trig_ok   = 1'b1;
      end
    end
  end

  assign w_trig_match = w_trig_ok && (((w_trig_word ^ trig_value) & trig_mask) == '0);
  assign w_active     = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_limit      = w_active && (r_cycle_count == LIMIT_L);
  assign w_hit        = (r_state == S_ARMED) && probe_valid && w_trig_match;
  assign w_post_done  = (r_state == S_POST) && probe_valid && (r_post_cnt == AW'(1));
  assign w_wr_en      = !reset && !arm && probe_valid && w_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Normal completion is tested before the cycle limit so it wins a tie.
  always_comb begin
    w_state_next  = r_state;
    w_set_timeout = 1'b0;
    if (arm) begin
      w_state_next = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_hit && (POST == 0)) begin
            w_state_next = S_DONE;
          end else if (w_limit) begin
            w_state_next  = S_DONE;
            w_set_timeout = 1'b1;
          end else if (w_hit) begin
            w_state_next = S_POST;
          end
        end
        S_POST: begin
          if (w_post_done) begin
            w_state_next = S_DONE;
          end else if (w_limit) begin
            w_state_next  = S_DONE;
            w_set_timeout = 1'b1;
          end
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_trig_addr    <= '0;
      r_post_cnt     <= '0;
      r_sample_count <= '0;
      r_triggered    <= 1'b0;
      r_timeout      <= 1'b0;
      r_cycle_count  <= '0;
    end else if (arm) begin
      r_wr_ptr       <= '0;
      r_trig_addr    <= '0;
      r_post_cnt     <= '0;
      r_sample_count <= '0;
      r_triggered    <= 1'b0;
      r_timeout      <= 1'b0;
      r_cycle_count  <= '0;
    end else if (w_active) begin
      r_cycle_count <= r_cycle_count + 1'b1;
      if (probe_valid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_sample_count != DEPTH_L) begin
          r_sample_count <= r_sample_count + 1'b1;
        end
        if (r_state == S_POST) begin
          r_post_cnt <= r_post_cnt - 1'b1;
        end
      end
      if (w_hit) begin
        r_triggered <= 1'b1;
        r_trig_addr <= r_wr_ptr;
        r_post_cnt  <= POST_L;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= probe;
    end
  end

  assign w_oldest  = (r_sample_count == DEPTH_L) ? r_wr_ptr : '0;
  assign w_rd_phys = w_oldest + rd_addr;
  assign w_rd_word = r_mem[w_rd_phys];

  always_comb begin
    w_rd_sel     = '0;
    w_rd_chan_ok = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(rd_chan) == c) begin
        w_rd_sel     = w_rd_word[c*WIDTH +: WIDTH];
        w_rd_chan_ok = 1'b1;
      end
    end
  end

  assign w_rd_in_range = ({1'b0, rd_addr} < r_sample_count) && w_rd_chan_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (w_rd_in_range) begin
      r_rd_data <= w_rd_sel;
    end else begin
      r_rd_data <= '0;
    end
  end

  assign rd_data      = r_rd_data;
  assign state        = r_state;
  assign sample_count = r_sample_count;
  assign triggered    = r_triggered;
  assign timeout      = r_timeout;
  assign cycle_count  = r_cycle_count;
  assign trig_index   = (r_triggered && (r_state == S_DONE)) ? (r_trig_addr - w_oldest) : '0;

endmodule

// File: tb/tb_agc_trace_capture.sv
// tb/tb_agc_trace_capture.sv - scoreboard bench for agc_trace_capture
module tb_agc_trace_capture;
  localparam int WIDTH      = 16;
  localparam int CHANNELS   = 4;
  localparam int DEPTH      = 8;
  localparam int POST       = 2;
  localparam int MAX_CYCLES = 20;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] probe;
  logic                      probe_valid;
  logic                      arm;
  logic [1:0]                trig_chan;
  logic [WIDTH-1:0]          trig_value;
  logic [WIDTH-1:0]          trig_mask;
  logic [2:0]                rd_addr;
  logic [1:0]                rd_chan;
  logic [WIDTH-1:0]          rd_data;
  logic [1:0]                state;
  logic [3:0]                sample_count;
  logic [2:0]                trig_index;
  logic                      triggered;
  logic                      timeout;
  logic [4:0]                cycle_count;

  agc_trace_capture #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .POST(POST), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .probe(probe), .probe_valid(probe_valid), .arm(arm),
    .trig_chan(trig_chan), .trig_value(trig_value), .trig_mask(trig_mask),
    .rd_addr(rd_addr), .rd_chan(rd_chan), .rd_data(rd_data), .state(state),
    .sample_count(sample_count), .trig_index(trig_index), .triggered(triggered),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kind;
    int    exp;
    int    due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input int kind);
    case (kind)
      0:       return {30'b0, state};
      1:       return {28'b0, sample_count};
      2:       return {29'b0, trig_index};
      3:       return {31'b0, triggered};
      4:       return {31'b0, timeout};
      5:       return {27'b0, cycle_count};
      default: return {16'b0, rd_data};
    endcase
  endfunction

  // Monitor: compares every expectation whose output is due by now.
  always @(negedge clk) begin
    exp_t        it;
    logic [31:0] got;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      it  = exp_q.pop_front();
      got = pick(it.kind);
      checks++;
      if (got !== 32'(it.exp)) begin
        errors++;
        $display("FAIL %s got %0h expected %0h", it.name, got, it.exp);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int kind, input int exp, input int due);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.exp  = exp;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic status(input string tag, input int st, input int cnt, input int ti,
                        input int trg, input int to);
    expect_out({tag, "_state"}, 0, st, cyc);
    expect_out({tag, "_count"}, 1, cnt, cyc);
    expect_out({tag, "_tidx"}, 2, ti, cyc);
    expect_out({tag, "_trig"}, 3, trg, cyc);
    expect_out({tag, "_tout"}, 4, to, cyc);
  endtask

  task automatic cyc_expect(input string tag, input int v);
    expect_out(tag, 5, v, cyc);
  endtask

  task automatic rd(input int a, input int ch, input int exp, input string nm);
    probe_valid = 1'b0;
    rd_addr     = 3'(a);
    rd_chan     = 2'(ch);
    expect_out($sformatf("%s_a%0d_c%0d", nm, a, ch), 6, exp, cyc + 1);
    tick();
  endtask

  task automatic send(input logic v, input logic [15:0] c0, input logic [15:0] c2);
    probe       = {~c0, c2, c0 ^ 16'h0100, c0};
    probe_valid = v;
    tick();
  endtask

  task automatic do_arm(input logic [15:0] c0, input logic [15:0] c2);
    arm = 1'b1;
    send(1'b1, c0, c2);
    arm = 1'b0;
  endtask

  task automatic set_trig(input int ch, input logic [15:0] val, input logic [15:0] mask);
    trig_chan  = 2'(ch);
    trig_value = val;
    trig_mask  = mask;
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; probe_valid = 1'b1; probe = '0;
    rd_addr = '0; rd_chan = '0;
    set_trig(0, 16'h0000, 16'h0000);

    send(1'b1, 16'h1111, 16'h2222);
    send(1'b1, 16'hEEEE, 16'hDDDD);
    status("rst", 0, 0, 0, 0, 0);
    cyc_expect("rst_cyc", 0);
    expect_out("rst_rd", 6, 0, cyc);
    reset = 1'b0;
    probe_valid = 1'b0;
    tick();

    // Basic trigger
    set_trig(0, 16'd5, 16'hFFFF);
    do_arm(16'd5, 16'h0);
    status("b_arm", 1, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      send(1'b1, 16'(i), 16'h0);
      if (i == 5) status("b_trig", 2, 5, 0, 1, 0);
    end
    status("b_done", 3, 7, 4, 1, 0);
    cyc_expect("b_cyc", 7);
    send(1'b1, 16'd8, 16'h0);
    status("b_hold", 3, 7, 4, 1, 0);
    for (int a = 0; a < 7; a++) rd(a, 0, a + 1, "b_rd");
    rd(7, 0, 0, "b_rd_oob");
    rd(2, 1, 16'h0103, "b_rd");
    rd(0, 3, 16'hFFFE, "b_rd");

    // Wrap
    set_trig(0, 16'd12, 16'hFFFF);
    do_arm(16'd0, 16'h0);
    for (int i = 1; i <= 14; i++) begin
      send(1'b1, 16'(i), 16'h0);
      if (i == 13) status("w_post", 2, 8, 0, 1, 0);
    end
    status("w_done", 3, 8, 5, 1, 0);
    cyc_expect("w_cyc", 14);
    for (int a = 0; a < 8; a++) rd(a, 0, a + 7, "w_rd");

    // Masked trigger on channel 2
    set_trig(2, 16'h0030, 16'h00F0);
    do_arm(16'd0, 16'h1230);
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 16'(i + 1), 16'(16'h1200 + 16 * i));
      if (i == 2) status("m_pre", 1, 3, 0, 0, 0);
      if (i == 3) status("m_trig", 2, 4, 0, 1, 0);
    end
    status("m_done", 3, 6, 3, 1, 0);
    rd(3, 2, 16'h1230, "m_rd");
    rd(0, 2, 16'h1200, "m_rd");
    rd(6, 2, 0, "m_rd_oob");

    // Timeout with no match
    set_trig(0, 16'hFFFF, 16'hFFFF);
    do_arm(16'd0, 16'h0);
    for (int i = 1; i <= 20; i++) begin
      send(1'b1, 16'(i), 16'h0);
      if (i == 19) begin
        status("t_pre", 1, 8, 0, 0, 0);
        cyc_expect("t_pre_cyc", 19);
      end
    end
    status("t_done", 3, 8, 0, 0, 1);
    cyc_expect("t_cyc", 20);
    for (int a = 0; a < 8; a++) rd(a, 0, a + 13, "t_rd");

    // Trigger in the timeout cycle
    set_trig(0, 16'd20, 16'hFFFF);
    do_arm(16'd0, 16'h0);
    for (int i = 1; i <= 20; i++) send(1'b1, 16'(i), 16'h0);
    status("tt", 3, 8, 7, 1, 1);
    cyc_expect("tt_cyc", 20);

    // Completion coincides with timeout cycle
    set_trig(0, 16'd18, 16'hFFFF);
    do_arm(16'd0, 16'h0);
    for (int i = 1; i <= 20; i++) begin
      send(1'b1, 16'(i), 16'h0);
      if (i == 18) status("tc_post", 2, 8, 0, 1, 0);
    end
    status("tc", 3, 8, 5, 1, 0);

    // Gaps: invalid cycles carry a matching value that must be ignored
    set_trig(0, 16'd3, 16'hFFFF);
    do_arm(16'd0, 16'h0);
    send(1'b0, 16'd3, 16'h0);
    status("g0", 1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      send(1'b1, 16'(k), 16'h0);
      if (k == 3) status("g_trig", 2, 3, 0, 1, 0);
      if (k < 5) send(1'b0, 16'd3, 16'h0);
      if (k == 4) status("g_gap", 2, 4, 0, 1, 0);
    end
    status("g_done", 3, 5, 2, 1, 0);
    cyc_expect("g_cyc", 10);
    for (int a = 0; a < 5; a++) rd(a, 0, a + 1, "g_rd");

    // Rearm mid-POST
    do_arm(16'd0, 16'h0);
    for (int i = 1; i <= 4; i++) send(1'b1, 16'(i), 16'h0);
    status("rb", 2, 4, 0, 1, 0);
    do_arm(16'd9, 16'h0);
    status("ra", 1, 0, 0, 0, 0);
    cyc_expect("ra_cyc", 0);
    send(1'b1, 16'd7, 16'h0);
    status("ra1", 1, 1, 0, 0, 0);
    rd(0, 0, 7, "ra_rd");
    rd(1, 0, 0, "ra_rd_oob");

    // Zero mask fires on the first valid sample
    set_trig(0, 16'h1234, 16'h0000);
    do_arm(16'd0, 16'h0);
    send(1'b1, 16'hAAAA, 16'h0);
    status("z_trig", 2, 1, 0, 1, 0);
    send(1'b1, 16'hBBBB, 16'h0);
    send(1'b1, 16'hCCCC, 16'h0);
    status("z_done", 3, 3, 0, 1, 0);

    probe_valid = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
